// File: rtl/spike_fifo_arbiter.sv
// Purpose: drains NUM_SRC FWFT spike FIFOs round-robin into one downstream FIFO, one timestep per ts_start.
// Latency: source head reaches dst_din/dst_wr_en combinationally in XFER; one ARB cycle between grants.
// Backpressure: dst_full holds the current grant in XFER with nothing popped or pushed until it clears.
module spike_fifo_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_MAX  = 4,
    parameter int SRC_W      = $clog2(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ts_start,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_dout,
    input  logic [NUM_SRC-1:0]            src_empty,
    output logic [NUM_SRC-1:0]            src_rd_en,
    output logic [DATA_WIDTH-1:0]         dst_din,
    output logic [SRC_W-1:0]              dst_src_id,
    output logic                          dst_wr_en,
    input  logic                          dst_full,
    output logic                          busy,
    output logic                          ts_done,
    output logic [15:0]                   spike_count
);

    localparam int BC_W = $clog2(BURST_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SRC_W-1:0] grant;
    logic [SRC_W-1:0] last_grant;
    logic [BC_W-1:0]  burst_cnt;
    logic [SRC_W-1:0] arb_idx;
    logic             arb_found;
    logic [SRC_W:0]   cand_sum;
    logic             xfer;
    logic             burst_last;

    // A word moves only when the granted source has data and downstream has room.
    assign xfer       = (state == XFER) && !src_empty[grant] && !dst_full;
    assign burst_last = (burst_cnt == BC_W'(BURST_MAX - 1));

    // Round-robin search: walk from last_grant+1 with wrap; iterating downward lets the nearest hit win.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand_sum  = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand_sum = {1'b0, last_grant} + (SRC_W + 1)'(k);
            if (cand_sum >= (SRC_W + 1)'(NUM_SRC)) begin
                cand_sum = cand_sum - (SRC_W + 1)'(NUM_SRC);
            end
            if (!src_empty[cand_sum[SRC_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand_sum[SRC_W-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: an empty grant or a finished burst sends XFER back to arbitration.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (ts_start) state_nxt = ARB;
            ARB:  state_nxt = arb_found ? XFER : DONE;
            XFER: begin
                if (src_empty[grant]) begin
                    state_nxt = ARB;
                end else if (!dst_full && burst_last) begin
                    state_nxt = ARB;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant, rotation pointer, burst length and per-timestep word count.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant       <= '0;
            last_grant  <= SRC_W'(NUM_SRC - 1);
            burst_cnt   <= '0;
            spike_count <= '0;
        end else begin
            if (state == IDLE && ts_start) begin
                spike_count <= '0;
            end
            if (state == ARB && arb_found) begin
                grant     <= arb_idx;
                burst_cnt <= '0;
            end
            if (state == XFER) begin
                if (src_empty[grant]) begin
                    last_grant <= grant;
                end else if (!dst_full) begin
                    burst_cnt <= burst_cnt + BC_W'(1);
                    if (spike_count != 16'hFFFF) begin
                        spike_count <= spike_count + 16'd1;
                    end
                    if (burst_last) begin
                        last_grant <= grant;
                    end
                end
            end
        end
    end

    // Outputs: strobes only on a real transfer, data path parked at zero while idle or in reset.
    always_comb begin
        src_rd_en  = '0;
        dst_wr_en  = 1'b0;
        dst_din    = '0;
        dst_src_id = '0;
        busy       = 1'b0;
        ts_done    = 1'b0;
        if (!rst) begin
            busy    = (state != IDLE);
            ts_done = (state == DONE);
            if (state != IDLE) begin
                dst_src_id = grant;
                dst_din    = src_dout[int'(grant) * DATA_WIDTH +: DATA_WIDTH];
            end
            if (xfer) begin
                src_rd_en[grant] = 1'b1;
                dst_wr_en        = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spike_fifo_arbiter.sv
// Bench for spike_fifo_arbiter: FWFT source models, scoreboard of pushed words, per-cycle log.
// Directed timesteps on a 4-source instance plus a 3-source instance for wrap and fairness.
// Sources pop on the edge after the bench sees src_rd_en; inputs change 1 time unit after the edge.
module tb_spike_fifo_arbiter;

    localparam int N    = 4;
    localparam int N3   = 3;
    localparam int W    = 32;
    localparam int LOGN = 1024;
    localparam int MEMD = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic           ts_start;
    logic [N*W-1:0] src_dout;
    logic [N-1:0]   src_empty;
    logic [N-1:0]   src_rd_en;
    logic [W-1:0]   dst_din;
    logic [1:0]     dst_src_id;
    logic           dst_wr_en;
    logic           dst_full;
    logic           busy;
    logic           ts_done;
    logic [15:0]    spike_count;

    logic            rst3;
    logic            ts_start3;
    logic [N3*W-1:0] src_dout3;
    logic [N3-1:0]   src_empty3;
    logic [N3-1:0]   src_rd_en3;
    logic [W-1:0]    dst_din3;
    logic [1:0]      dst_src_id3;
    logic            dst_wr_en3;
    logic            busy3;
    logic            ts_done3;
    logic [15:0]     spike_count3;

    spike_fifo_arbiter #(.NUM_SRC(N), .DATA_WIDTH(W), .BURST_MAX(4)) dut (
        .clk(clk), .rst(rst), .ts_start(ts_start), .src_dout(src_dout), .src_empty(src_empty),
        .src_rd_en(src_rd_en), .dst_din(dst_din), .dst_src_id(dst_src_id), .dst_wr_en(dst_wr_en),
        .dst_full(dst_full), .busy(busy), .ts_done(ts_done), .spike_count(spike_count)
    );

    spike_fifo_arbiter #(.NUM_SRC(N3), .DATA_WIDTH(W), .BURST_MAX(4)) dut3 (
        .clk(clk), .rst(rst3), .ts_start(ts_start3), .src_dout(src_dout3), .src_empty(src_empty3),
        .src_rd_en(src_rd_en3), .dst_din(dst_din3), .dst_src_id(dst_src_id3), .dst_wr_en(dst_wr_en3),
        .dst_full(1'b0), .busy(busy3), .ts_done(ts_done3), .spike_count(spike_count3)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Source storage: mem holds every word ever loaded; rp is the FIFO read side, ep the scoreboard side.
    logic [W-1:0] mem [N][MEMD];
    int           wp [N];
    int           rp [N];
    int           ep [N];
    int           c3 [2];
    logic [N-1:0]  rd_lat;
    logic [N3-1:0] rd3_lat;
    int           mcount = 0;

    int wr_log   [LOGN];
    int wr3_log  [LOGN];
    bit done_log [LOGN];
    bit busy_log [LOGN];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic update_src();
        for (int i = 0; i < N; i++) begin
            src_empty[i]       = (rp[i] >= wp[i]);
            src_dout[i*W +: W] = (rp[i] < wp[i] && rp[i] < MEMD) ? mem[i][rp[i]] : '0;
        end
        src_empty3 = {1'b0, c3[1] == 0, c3[0] == 0};
        src_dout3  = {32'h0000_0C02, 32'h0000_0C01, 32'h0000_0C00};
    endtask

    task automatic push(input int s, input logic [W-1:0] v);
        mem[s][wp[s]] = v;
        wp[s]++;
    endtask

    // One clock: sample pop strobes mid-cycle, then retire popped heads just after the edge.
    task automatic step();
        @(negedge clk);
        rd_lat  = src_rd_en;
        rd3_lat = src_rd_en3;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (rd_lat[i]) rp[i]++;
        for (int i = 0; i < 2; i++) if (rd3_lat[i]) c3[i]--;
        update_src();
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Per-cycle comparison against the model: scoreboard order, strobe shape, word count.
    always @(negedge clk) begin
        if (cyc < LOGN) begin
            wr_log[cyc]   = dst_wr_en ? int'(dst_src_id) : -1;
            wr3_log[cyc]  = dst_wr_en3 ? int'(dst_src_id3) : -1;
            done_log[cyc] = ts_done;
            busy_log[cyc] = busy;
        end
        if (!rst) begin
            check("spike_count", 64'(spike_count), 64'(mcount));
            check("rd_en_shape", 64'(src_rd_en), dst_wr_en ? 64'(1) << dst_src_id : 64'(0));
            if (dst_wr_en) begin
                check("push_while_full", 64'(dst_full), 64'(0));
                check("dst_din", 64'(dst_din),
                      (ep[dst_src_id] < MEMD) ? 64'(mem[dst_src_id][ep[dst_src_id]]) : 64'hDEAD);
                ep[dst_src_id]++;
            end
            if (ts_done) begin
                check("busy_at_done", 64'(busy), 64'(1));
                check("done_all_empty", 64'(src_empty), 64'hF);
            end
        end
        if (!rst3) begin
            check("rd3_shape", 64'(src_rd_en3), dst_wr_en3 ? 64'(1) << dst_src_id3 : 64'(0));
        end
        if (rst) mcount = 0;
        else if (ts_start && !busy) mcount = 0;
        else if (dst_wr_en && mcount < 65535) mcount++;
    end

    int t0;
    int exp_id;
    int got [$];
    int ndone;
    int lag;

    initial begin
        rst = 1'b1; rst3 = 1'b1; ts_start = 1'b0; ts_start3 = 1'b0; dst_full = 1'b0;
        for (int i = 0; i < N; i++) begin
            wp[i] = 0; rp[i] = 0; ep[i] = 0;
        end
        c3[0] = 0; c3[1] = 0;
        update_src();
        step();
        step();
        rst = 1'b0; rst3 = 1'b0;
        #2;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(ts_done), 64'(0));
        check("reset_wr", 64'(dst_wr_en), 64'(0));
        check("reset_rd", 64'(src_rd_en), 64'(0));
        check("reset_din", 64'(dst_din), 64'(0));
        check("reset_id", 64'(dst_src_id), 64'(0));
        check("reset_count", 64'(spike_count), 64'(0));

        // Single source, three words: writes 2..4, empty seen in XFER at 5, ARB 6, DONE 7.
        push(1, 32'hAAAA_0001); push(1, 32'hBBBB_0002); push(1, 32'hCCCC_0003);
        update_src();
        t0 = cyc; ts_start = 1'b1;
        step();
        ts_start = 1'b0;
        repeat (10) step();
        for (int k = 0; k < 9; k++) begin
            exp_id = (k >= 2 && k <= 4) ? 1 : -1;
            check("t1_wr", 64'(wr_log[t0+k]), 64'(exp_id));
        end
        check("t1_done7", 64'(done_log[t0+7]), 64'(1));
        check("t1_done6", 64'(done_log[t0+6]), 64'(0));
        check("t1_count", 64'(spike_count), 64'(3));
        check("t1_popped", 64'(ep[1]), 64'(3));

        // Four sources of six words: full bursts in order, then the two-word remainders.
        pulse_rst();
        for (int s = 0; s < N; s++)
            for (int k = 0; k < 6; k++) push(s, 32'h1000_0000 | (s << 8) | k);
        update_src();
        t0 = cyc; ts_start = 1'b1;
        step();
        ts_start = 1'b0;
        repeat (49) step();
        got.delete();
        ndone = 0;
        for (int c = t0; c < t0 + 50; c++) begin
            if (wr_log[c] >= 0) got.push_back(wr_log[c]);
            if (done_log[c]) ndone++;
        end
        check("t2_nwr", 64'(got.size()), 64'(24));
        for (int i = 0; i < 24 && i < got.size(); i++)
            check("t2_order", 64'(got[i]), 64'((i < 16) ? i / 4 : (i - 16) / 2));
        check("t2_done_at", 64'(done_log[t0+38]), 64'(1));
        check("t2_ndone", 64'(ndone), 64'(1));
        check("t2_count", 64'(spike_count), 64'(24));

        // Stall after the second burst word for five cycles; burst resumes and still totals four.
        pulse_rst();
        for (int k = 0; k < 4; k++) push(0, 32'h3000_0000 | k);
        update_src();
        t0 = cyc;
        for (int k = 0; k < 16; k++) begin
            ts_start = (k == 0);
            dst_full = (k >= 4 && k <= 8);
            step();
        end
        ts_start = 1'b0; dst_full = 1'b0;
        for (int k = 0; k < 14; k++) begin
            exp_id = (k == 2 || k == 3 || k == 9 || k == 10) ? 0 : -1;
            check("t3_wr", 64'(wr_log[t0+k]), 64'(exp_id));
        end
        check("t3_done", 64'(done_log[t0+12]), 64'(1));
        check("t3_count", 64'(spike_count), 64'(4));

        // Nothing queued: ARB then DONE immediately.
        t0 = cyc; ts_start = 1'b1;
        step();
        ts_start = 1'b0;
        repeat (4) step();
        check("t4_busy0", 64'(busy_log[t0]), 64'(0));
        check("t4_busy1", 64'(busy_log[t0+1]), 64'(1));
        check("t4_busy2", 64'(busy_log[t0+2]), 64'(1));
        check("t4_busy3", 64'(busy_log[t0+3]), 64'(0));
        check("t4_done1", 64'(done_log[t0+1]), 64'(0));
        check("t4_done2", 64'(done_log[t0+2]), 64'(1));
        check("t4_count", 64'(spike_count), 64'(0));

        // Second ts_start while transferring is ignored: one done, all eight words counted.
        for (int k = 0; k < 6; k++) push(0, 32'h5000_0000 | k);
        push(2, 32'h5200_0000); push(2, 32'h5200_0001);
        update_src();
        t0 = cyc;
        for (int k = 0; k < 40; k++) begin
            ts_start = (k == 0 || k == 3);
            step();
        end
        ts_start = 1'b0;
        ndone = 0;
        for (int c = t0; c < t0 + 40; c++) if (done_log[c]) ndone++;
        check("t5_ndone", 64'(ndone), 64'(1));
        check("t5_count", 64'(spike_count), 64'(8));

        // Reset in the middle of a burst: the reset-cycle word stays in its source.
        for (int k = 0; k < 6; k++) push(1, 32'h5100_0000 | k);
        update_src();
        t0 = cyc;
        for (int k = 0; k < 5; k++) begin
            ts_start = (k == 0);
            rst      = (k == 4);
            step();
        end
        ts_start = 1'b0; rst = 1'b0;
        #2;
        check("t5_rstcyc_wr", 64'(wr_log[t0+4]), 64'(-1));
        check("t5_rst_busy", 64'(busy), 64'(0));
        check("t5_rst_wr", 64'(dst_wr_en), 64'(0));
        check("t5_rst_rd", 64'(src_rd_en), 64'(0));
        check("t5_rst_din", 64'(dst_din), 64'(0));
        check("t5_rst_id", 64'(dst_src_id), 64'(0));
        check("t5_rst_count", 64'(spike_count), 64'(0));
        check("t5_left", 64'(wp[1] - rp[1]), 64'(4));

        // After reset the search restarts at source 0 even with source 1 still holding words.
        push(0, 32'h5000_00FF);
        update_src();
        t0 = cyc; ts_start = 1'b1;
        step();
        ts_start = 1'b0;
        repeat (19) step();
        check("t5_first_id", 64'(wr_log[t0+2]), 64'(0));
        got.delete();
        for (int c = t0; c < t0 + 20; c++) if (wr_log[c] >= 0) got.push_back(wr_log[c]);
        check("t5_nwr", 64'(got.size()), 64'(5));
        check("t5_count2", 64'(spike_count), 64'(5));

        // Three sources, source 2 never empties; source 0 refilled mid-burst and granted after the wrap.
        c3[0] = 2; c3[1] = 2;
        update_src();
        t0 = cyc;
        for (int k = 0; k < 24; k++) begin
            ts_start3 = (k == 0);
            if (k == 10) begin
                c3[0] = c3[0] + 1;
                update_src();
            end
            step();
        end
        ts_start3 = 1'b0;
        for (int k = 0; k < 22; k++) begin
            if (k == 2 || k == 3 || k == 15) exp_id = 0;
            else if (k == 6 || k == 7) exp_id = 1;
            else if ((k >= 10 && k <= 13) || (k >= 18 && k <= 21)) exp_id = 2;
            else exp_id = -1;
            check("t6_wr", 64'(wr3_log[t0+k]), 64'(exp_id));
        end
        lag = 99;
        for (int k = 21; k >= 10; k--) if (wr3_log[t0+k] == 0) lag = k - 10;
        check("t6_fair", 64'(lag <= 10), 64'(1));
        rst3 = 1'b1;
        step();
        rst3 = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
